// File: rtl/placar_controle_if.sv
// Board-side signal bundle of the scoreboard controller: raw buttons/switches in,
// scores, LEDs, buzzer and busy flag out.
interface placar_controle_if;
  logic [2:0] cBotoes;
  logic       chaveNP;
  logic       chaveTime;
  logic [6:0] placarA;
  logic [6:0] placarB;
  logic [1:0] led;
  logic       buzzer;
  logic       ocupado;

  modport master (
    output cBotoes, chaveNP, chaveTime,
    input  placarA, placarB, led, buzzer, ocupado
  );

  modport slave (
    input  cBotoes, chaveNP, chaveTime,
    output placarA, placarB, led, buzzer, ocupado
  );
endinterface

// File: rtl/placar_controle.sv
// Basketball scoreboard sequencer: synchronises and debounces the point buttons,
// applies one saturating score update per qualified press and pulses the buzzer.
module placar_controle #(
  parameter int SCORE_MAX   = 99,
  parameter int DEB_CYCLES  = 50000,
  parameter int BUZZ_CYCLES = 5000000
) (
  input logic              clock,
  input logic              reset,
  placar_controle_if.slave bus
);

  typedef enum logic [1:0] {ESPERA, OCIOSO, APLICA, BUZINA} state_t;

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_MAX   = CW'(DEB_CYCLES);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
  localparam logic [7:0]    MAX8      = 8'(SCORE_MAX);

  state_t        state_q, state_d;
  logic [2:0]    bs_s1_q, bs_s1_d, bs_q, bs_d;
  logic          np_s1_q, np_s1_d, np_q, np_d;
  logic          tm_s1_q, tm_s1_d, tm_q, tm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] buzz_q, buzz_d;
  logic [1:0]    delta_q, delta_d;
  logic          op_q, op_d;
  logic          team_q, team_d;
  logic [6:0]    score_a_q, score_a_d, score_b_q, score_b_d;

  logic          stable;
  logic [6:0]    sel, res;
  logic [7:0]    sum;

  always_comb begin
    bs_s1_d = bus.cBotoes;
    bs_d    = bs_s1_q;
    np_s1_d = bus.chaveNP;
    np_d    = np_s1_q;
    tm_s1_d = bus.chaveTime;
    tm_d    = tm_s1_q;

    // Qualification happens on the edge the counter reaches its limit, which
    // puts it 2 + DEB_CYCLES edges after the raw input changes.
    if (bs_d != bs_q)          cnt_d = '0;
    else if (cnt_q == DEB_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + CW'(1);
    stable = (cnt_d == DEB_MAX);

    sel = team_q ? score_b_q : score_a_q;
    sum = {1'b0, sel} + {6'b0, delta_q};
    if (op_q) res = (sel < {5'b0, delta_q}) ? '0 : sel - {5'b0, delta_q};
    else      res = (sum > MAX8) ? MAX8[6:0] : sum[6:0];

    state_d   = state_q;
    buzz_d    = buzz_q;
    delta_d   = delta_q;
    op_d      = op_q;
    team_d    = team_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;

    case (state_q)
      ESPERA: if (stable && bs_q == '0) state_d = OCIOSO;
      OCIOSO: begin
        if (stable && bs_q != '0) begin
          if ($onehot(bs_q)) begin
            state_d = APLICA;
            delta_d = bs_q[0] ? 2'd1 : (bs_q[1] ? 2'd2 : 2'd3);
            op_d    = np_q;
            team_d  = tm_q;
          end else begin
            state_d = ESPERA;
          end
        end
      end
      APLICA: begin
        state_d = BUZINA;
        buzz_d  = '0;
        if (team_q) score_b_d = res;
        else        score_a_d = res;
      end
      BUZINA: begin
        if (buzz_q == BUZZ_LAST) state_d = ESPERA;
        else                     buzz_d  = buzz_q + BW'(1);
      end
      default: state_d = ESPERA;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ESPERA;
      bs_s1_q   <= '0;
      bs_q      <= '0;
      np_s1_q   <= 1'b0;
      np_q      <= 1'b0;
      tm_s1_q   <= 1'b0;
      tm_q      <= 1'b0;
      cnt_q     <= '0;
      buzz_q    <= '0;
      delta_q   <= '0;
      op_q      <= 1'b0;
      team_q    <= 1'b0;
      score_a_q <= '0;
      score_b_q <= '0;
    end else begin
      state_q   <= state_d;
      bs_s1_q   <= bs_s1_d;
      bs_q      <= bs_d;
      np_s1_q   <= np_s1_d;
      np_q      <= np_d;
      tm_s1_q   <= tm_s1_d;
      tm_q      <= tm_d;
      cnt_q     <= cnt_d;
      buzz_q    <= buzz_d;
      delta_q   <= delta_d;
      op_q      <= op_d;
      team_q    <= team_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
    end
  end

  assign bus.placarA = score_a_q;
  assign bus.placarB = score_b_q;
  assign bus.led     = {score_b_q >= score_a_q, score_a_q >= score_b_q};
  assign bus.buzzer  = (state_q == BUZINA);
  assign bus.ocupado = (state_q != OCIOSO);

endmodule

// File: tb/tb_placar_controle.sv
// Directed bench for placar_controle with DEB_CYCLES = 4 and BUZZ_CYCLES = 8.
module tb_placar_controle;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   buzz_seen;

  placar_controle_if bus ();

  placar_controle #(
    .SCORE_MAX  (99),
    .DEB_CYCLES (4),
    .BUZZ_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_count(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.buzzer === 1'b1) buzz_seen++;
    end
  endtask

  // Press, hold through the buzz, flip the switches mid-buzz, then release.
  task automatic do_press(input logic [2:0] b, input logic n, input logic t);
    bus.cBotoes   = b;
    bus.chaveNP   = n;
    bus.chaveTime = t;
    buzz_seen     = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.buzzer === 1'b1) buzz_seen++;
      if (i == 8) begin
        bus.chaveNP   = ~n;
        bus.chaveTime = ~t;
      end
    end
    bus.cBotoes = 3'b000;
    wait_count(10);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    buzz_seen     = 0;
    reset         = 1'b1;
    bus.cBotoes   = 3'b000;
    bus.chaveNP   = 1'b0;
    bus.chaveTime = 1'b0;
    step();
    step();
    check("rst_placarA", 32'(bus.placarA), 0);
    check("rst_placarB", 32'(bus.placarB), 0);
    check("rst_buzzer",  32'(bus.buzzer),  0);
    check("rst_led",     32'(bus.led),     3);
    check("rst_ocupado", 32'(bus.ocupado), 1);
    reset = 1'b0;
    step();
    wait_count(9);
    check("idle_ocupado", 32'(bus.ocupado), 0);

    // 1: +3 to team A, update lands on the 7th edge after the press
    bus.cBotoes = 3'b100;
    for (int i = 0; i < 6; i++) step();
    check("s1_before_update", 32'(bus.placarA), 0);
    step();
    check("s1_placarA", 32'(bus.placarA), 3);
    check("s1_buzzer_on", 32'(bus.buzzer), 1);
    check("s1_placarB", 32'(bus.placarB), 0);
    check("s1_led", 32'(bus.led), 1);
    buzz_seen = 1;
    wait_count(12);
    check("s1_buzz_len", 32'(buzz_seen), 8);
    check("s1_held_ocupado", 32'(bus.ocupado), 1);
    bus.cBotoes = 3'b000;
    wait_count(10);
    check("s1_release_ocupado", 32'(bus.ocupado), 0);
    check("s1_placarA_hold", 32'(bus.placarA), 3);

    // 3: subtract down to 2, then clamp at 0
    do_press(3'b001, 1'b1, 1'b0);
    check("s3_sub1", 32'(bus.placarA), 2);
    do_press(3'b100, 1'b1, 1'b0);
    check("s3_clamp", 32'(bus.placarA), 0);
    check("s3_led_tie", 32'(bus.led), 3);

    // 2: team B to 98 then saturate at 99
    for (int k = 0; k < 32; k++) do_press(3'b100, 1'b0, 1'b1);
    do_press(3'b010, 1'b0, 1'b1);
    check("s2_placarB_98", 32'(bus.placarB), 98);
    check("s2_led_b", 32'(bus.led), 2);
    do_press(3'b100, 1'b0, 1'b1);
    check("s2_sat", 32'(bus.placarB), 99);
    check("s2_buzz", 32'(buzz_seen), 8);
    do_press(3'b100, 1'b0, 1'b1);
    check("s2_sat_again", 32'(bus.placarB), 99);
    check("s2_buzz_again", 32'(buzz_seen), 8);
    check("s2_placarA", 32'(bus.placarA), 0);

    // 4: bounce shorter than the debounce window, then a long hold
    buzz_seen     = 0;
    bus.chaveNP   = 1'b0;
    bus.chaveTime = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.cBotoes = 3'b001;
      wait_count(2);
      bus.cBotoes = 3'b000;
      wait_count(2);
    end
    wait_count(15);
    check("s4_bounce_A", 32'(bus.placarA), 0);
    check("s4_bounce_B", 32'(bus.placarB), 99);
    check("s4_bounce_buzz", 32'(buzz_seen), 0);
    bus.cBotoes = 3'b001;
    wait_count(100);
    bus.cBotoes = 3'b000;
    wait_count(10);
    check("s4_hold_A", 32'(bus.placarA), 1);
    check("s4_hold_buzz", 32'(buzz_seen), 8);

    // 5: invalid two-button combination
    buzz_seen   = 0;
    bus.cBotoes = 3'b011;
    wait_count(20);
    check("s5_A", 32'(bus.placarA), 1);
    check("s5_B", 32'(bus.placarB), 99);
    check("s5_buzz", 32'(buzz_seen), 0);
    check("s5_ocupado", 32'(bus.ocupado), 1);
    bus.cBotoes = 3'b000;
    wait_count(10);
    check("s5_release_ocupado", 32'(bus.ocupado), 0);
    do_press(3'b001, 1'b0, 1'b0);
    check("s5_next_press", 32'(bus.placarA), 2);

    // 6: reset in the middle of the buzz with the button held
    bus.cBotoes   = 3'b001;
    bus.chaveNP   = 1'b0;
    bus.chaveTime = 1'b0;
    wait_count(10);
    check("s6_pre_A", 32'(bus.placarA), 3);
    check("s6_pre_buzz", 32'(bus.buzzer), 1);
    reset = 1'b1;
    #1;
    check("s6_rst_A", 32'(bus.placarA), 0);
    check("s6_rst_B", 32'(bus.placarB), 0);
    check("s6_rst_buzz", 32'(bus.buzzer), 0);
    check("s6_rst_led", 32'(bus.led), 3);
    step();
    step();
    reset     = 1'b0;
    buzz_seen = 0;
    wait_count(30);
    check("s6_held_A", 32'(bus.placarA), 0);
    check("s6_held_buzz", 32'(buzz_seen), 0);
    check("s6_held_ocupado", 32'(bus.ocupado), 1);
    bus.cBotoes = 3'b000;
    wait_count(10);
    check("s6_release_ocupado", 32'(bus.ocupado), 0);
    do_press(3'b001, 1'b0, 1'b1);
    check("s6_new_B", 32'(bus.placarB), 1);
    check("s6_new_A", 32'(bus.placarA), 0);
    check("s6_led", 32'(bus.led), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/placar_controle.md
Name: placar_controle

Overview:
Sequencing controller for the basketball scoreboard datapath.
- Synchronises and debounces the three point buttons and the add/subtract and team switches.
- Turns one qualified press into exactly one saturating score update on team A or team B.
- Drives the buzzer confirmation pulse and the "leading team" LEDs.
- Sits between the raw board inputs and the display/decoder logic, and owns the two score registers.

Parameters:
SCORE_MAX, 99, upper saturation limit of each score. Must be ≤ 127.
DEB_CYCLES, 50000, consecutive stable cycles required to qualify a press or a release. Must be ≥ 1.
BUZZ_CYCLES, 5000000, buzzer pulse length in clock cycles. Must be ≥ 1.

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
cBotoes  input  3  raw buttons, active-high: [0]=1 pt, [1]=2 pts, [2]=3 pts
chaveNP  input  1  0 = add points, 1 = subtract points
chaveTime  input  1  0 = team A, 1 = team B
placarA  output  7  team A score, unsigned
placarB  output  7  team B score, unsigned
led  output  2  [0]=1 when A ≥ B; [1]=1 when B ≥ A; both 1 on a tie
buzzer  output  1  confirmation pulse
ocupado  output  1  1 whenever the FSM state is not OCIOSO

Behaviour:
- Synchronisation: cBotoes, chaveNP and chaveTime each pass through a 2-FF synchroniser. All logic below uses only the synchronised values (bs, np, tm).
- Debounce counter: counts consecutive cycles in which bs equals its value on the previous cycle. It clears on any change of bs and saturates at DEB_CYCLES.
- "Stable" means the debounce counter equals DEB_CYCLES.
- Reset (asynchronous, any time, including mid-update or mid-buzz):
  - placarA = 0, placarB = 0, buzzer = 0
  - synchronisers and counters cleared
  - state = ESPERA
  - Consequence: a button held through reset never scores.
- FSM states and transitions:
  - ESPERA → OCIOSO when bs == 0 and stable.
  - OCIOSO → APLICA when bs is one-hot and stable. On that edge latch delta (1, 2 or 3), op = np and team = tm.
  - OCIOSO → ESPERA when bs is non-zero, not one-hot, and stable. This is an invalid combination: no update, no buzzer.
  - APLICA → BUZINA after one cycle. On this edge write the selected score register.
  - BUZINA: buzzer = 1 for exactly BUZZ_CYCLES cycles, starting on the APLICA→BUZINA edge. Then → ESPERA with buzzer = 0.
- Arithmetic: 7-bit unsigned.
  - Add: min(score + delta, SCORE_MAX).
  - Subtract: max(score − delta, 0). Never wraps.
  - Only the selected team's register changes; the other team's register holds.
- Latency: score update is 1 clock after qualification. Raw input to qualification is 2 + DEB_CYCLES cycles.
- Switches:
  - np and tm are sampled only at the qualifying edge.
  - Switch changes during APLICA, BUZINA or ESPERA have no effect on the update in progress.
- Press rules:
  - A button held indefinitely gives exactly one update. A new update needs a release (stable zero) followed by a new stable press.
  - Bounce shorter than DEB_CYCLES gives no update.
- led: combinational compare of the registered scores. After reset led = 2'b11 (0 = 0, tie).
- ocupado: combinational decode of the state (1 when not OCIOSO).

Test Plan:
All scenarios use DEB_CYCLES = 4 and BUZZ_CYCLES = 8.
1. Reset, all buttons 0 for 10 cycles; cBotoes=3'b100, chaveNP=0, chaveTime=0 held → placarA 0→3 exactly 7 cycles after press onset; buzzer high 8 cycles; placarB=0; led=2'b01.
2. placarB=98 via prior presses; chaveTime=1, press 3 pts → placarB=99 (saturated). Repeat press after release → stays 99; buzzer still pulses.
3. placarA=2; chaveNP=1, press 3 pts → placarA=0 (clamped, no wrap to 127); led=2'b11 when placarB=0.
4. Button toggled every 2 cycles for 20 cycles, then low → no score change, buzzer stays 0. Button held 100 cycles → exactly one update.
5. cBotoes=3'b011 stable → no update, no buzzer, ocupado=1 until release is stable. Then a 3'b001 press → +1.
6. Assert reset during BUZINA with button held → scores 0, buzzer 0 immediately. After reset release with the button still held → no update until release plus a new press.
